reg_access_arbiter: RTL and testbench

Round-robin arbiter that shares one register-slave port (req/ack/rd_wr_L protocol, as used by the core utility register blocks such as the device ID block) between NUM_REQ register masters. It sequences each access through the slave's handshake, returns read data and a one-cycle ack to the winning master, and enforces a timeout so a non-responding slave cannot hang the register bus. It sits between the core register decoder's masters and a single register slave.

---
 rtl/reg_access_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_reg_access_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
// Shares a single register-slave port between NUM_REQ register masters using
// round-robin arbitration. Each access is walked through the slave's
// req/ack/rd_wr_L handshake; the winning master receives read data and a
// one-cycle ack. A per-access timer forces completion (with 32'hdead_beef as
// read data) so a silent slave can never hang the register bus.
//
// Handshake semantics (both sides):
//   Master side: a master raises m_req[i] with stable m_rd_wr_L[i], m_addr and
//   m_wr_data and holds them until it sees m_ack[i]. m_ack[i] is a single-cycle
//   pulse; m_rd_data is valid in that cycle. The arbiter does not start another
//   access until the granted master has dropped m_req[i].
//   Slave side: slv_req rises with slv_addr/slv_wr_data/slv_rd_wr_L stable and
//   stays high until slv_ack is sampled high (or the timer expires). slv_req is
//   then low for at least one cycle before the next access, so the slave always
//   sees a clean request edge. slv_ack outside an access is ignored.
module reg_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  // master side
  input  logic [NUM_REQ-1:0]             m_req,
  input  logic [NUM_REQ-1:0]             m_rd_wr_L,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  m_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  m_wr_data,
  output logic [NUM_REQ-1:0]             m_ack,
  output logic [DATA_WIDTH-1:0]          m_rd_data,
  // slave side
  output logic                           slv_req,
  output logic                           slv_rd_wr_L,
  output logic [ADDR_WIDTH-1:0]          slv_addr,
  output logic [DATA_WIDTH-1:0]          slv_wr_data,
  input  logic                           slv_ack,
  input  logic [DATA_WIDTH-1:0]          slv_rd_data,
  // status
  output logic                           busy,
  output logic [15:0]                    timeout_count,
  output logic [1:0]                     state_dbg
);

  // Index width for master numbers and timer width sized to reach TIMEOUT.
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [GW-1:0]         LAST_IDX     = GW'(NUM_REQ - 1);
  localparam logic [TW-1:0]         TIMER_MAX    = TW'(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hdead_beef);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DROP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [TW-1:0]           timer_q, timer_d;

  logic [NUM_REQ-1:0]      m_ack_d;
  logic [DATA_WIDTH-1:0]   m_rd_data_d;
  logic                    slv_req_d;
  logic                    slv_rd_wr_L_d;
  logic [ADDR_WIDTH-1:0]   slv_addr_d;
  logic [DATA_WIDTH-1:0]   slv_wr_data_d;
  logic [15:0]             timeout_count_d;

  // Unpacked views of the flattened master buses.
  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

  // Round-robin search result.
  logic                    req_found;
  logic [GW-1:0]           req_sel;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = m_wr_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Master index `off` positions after `base`, wrapping at NUM_REQ.
  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_REQ;
    return GW'(s);
  endfunction

  // Find the first requesting master after the last winner, with wrap.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!req_found && m_req[wrap_idx(last_grant_q, k)]) begin
        req_found = 1'b1;
        req_sel   = wrap_idx(last_grant_q, k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-value logic for the access sequencer.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    timer_d         = timer_q;
    m_ack_d         = '0;
    m_rd_data_d     = m_rd_data;
    slv_req_d       = slv_req;
    slv_rd_wr_L_d   = slv_rd_wr_L;
    slv_addr_d      = slv_addr;
    slv_wr_data_d   = slv_wr_data;
    timeout_count_d = timeout_count;

    case (state_q)
      S_IDLE: begin
        if (req_found) begin
          grant_d       = req_sel;
          last_grant_d  = req_sel;
          slv_addr_d    = addr_arr[req_sel];
          slv_wr_data_d = wdata_arr[req_sel];
          slv_rd_wr_L_d = m_rd_wr_L[req_sel];
          slv_req_d     = 1'b1;
          timer_d       = '0;
          state_d       = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // A slave ack in the same cycle as expiry wins: real data, no count.
        if (slv_ack) begin
          m_rd_data_d      = slv_rd_data;
          m_ack_d[grant_q] = 1'b1;
          slv_req_d        = 1'b0;
          state_d          = S_WAIT_DROP;
        end else if (timer_q == TIMER_MAX) begin
          m_rd_data_d      = TIMEOUT_DATA;
          m_ack_d[grant_q] = 1'b1;
          slv_req_d        = 1'b0;
          if (timeout_count != 16'hffff) begin
            timeout_count_d = timeout_count + 16'd1;
          end
          state_d          = S_WAIT_DROP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_WAIT_DROP: begin
        // Hold off the next grant until the winner has seen its ack and let go.
        if (!m_req[grant_q]) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered datapath and outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q       <= '0;
      last_grant_q  <= LAST_IDX;
      timer_q       <= '0;
      m_ack         <= '0;
      m_rd_data     <= '0;
      slv_req       <= 1'b0;
      slv_rd_wr_L   <= 1'b1;
      slv_addr      <= '0;
      slv_wr_data   <= '0;
      timeout_count <= '0;
    end else begin
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      m_ack         <= m_ack_d;
      m_rd_data     <= m_rd_data_d;
      slv_req       <= slv_req_d;
      slv_rd_wr_L   <= slv_rd_wr_L_d;
      slv_addr      <= slv_addr_d;
      slv_wr_data   <= slv_wr_data_d;
      timeout_count <= timeout_count_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter (NUM_REQ=4, TIMEOUT=4).
// Inputs change on the falling edge; outputs are compared on the next falling
// edge, half a period after the rising edge that updated them.
module tb_reg_access_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int TIMEOUT    = 4;

  localparam logic [15:0] A0 = 16'h0100;
  localparam logic [15:0] A1 = 16'h0101;
  localparam logic [15:0] A2 = 16'h0005;
  localparam logic [15:0] A3 = 16'h0103;
  localparam logic [31:0] D0 = 32'hA000_0000;
  localparam logic [31:0] D1 = 32'hA000_0001;
  localparam logic [31:0] D2 = 32'hA000_0002;
  localparam logic [31:0] D3 = 32'hA000_0003;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NUM_REQ-1:0]            m_req;
  logic [NUM_REQ-1:0]            m_rd_wr_L;
  logic [NUM_REQ*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] m_wr_data;
  logic [NUM_REQ-1:0]            m_ack;
  logic [DATA_WIDTH-1:0]         m_rd_data;
  logic                          slv_req;
  logic                          slv_rd_wr_L;
  logic [ADDR_WIDTH-1:0]         slv_addr;
  logic [DATA_WIDTH-1:0]         slv_wr_data;
  logic                          slv_ack;
  logic [DATA_WIDTH-1:0]         slv_rd_data;
  logic                          busy;
  logic [15:0]                   timeout_count;
  logic [1:0]                    state_dbg;

  reg_access_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .m_req         (m_req),
    .m_rd_wr_L     (m_rd_wr_L),
    .m_addr        (m_addr),
    .m_wr_data     (m_wr_data),
    .m_ack         (m_ack),
    .m_rd_data     (m_rd_data),
    .slv_req       (slv_req),
    .slv_rd_wr_L   (slv_rd_wr_L),
    .slv_addr      (slv_addr),
    .slv_wr_data   (slv_wr_data),
    .slv_ack       (slv_ack),
    .slv_rd_data   (slv_rd_data),
    .busy          (busy),
    .timeout_count (timeout_count),
    .state_dbg     (state_dbg)
  );

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  rdwr;
    logic        ack;
    logic [31:0] srd;
    logic [3:0]  e_mack;
    logic        e_sreq;
    logic        e_srw;
    logic [15:0] e_saddr;
    logic [31:0] e_swd;
    logic        e_busy;
    logic [31:0] e_rdata;
    logic [15:0] e_tcnt;
  } vec_t;

  vec_t vecs [80];
  int   n_rows;
  int   n_vec;
  int   n_miss;

  // Slave-side fields expected from the most recent grant onward.
  logic [15:0] cur_addr;
  logic [31:0] cur_wd;
  logic        cur_rw;

  task automatic slv(input logic [15:0] a, input logic [31:0] d, input logic rw);
    cur_addr = a;
    cur_wd   = d;
    cur_rw   = rw;
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] rdwr, input logic ack,
                     input logic [31:0] srd, input logic [3:0] mack, input logic sreq,
                     input logic bsy, input logic [31:0] rdata, input logic [15:0] tcnt);
    vec_t v;
    v.req     = req;
    v.rdwr    = rdwr;
    v.ack     = ack;
    v.srd     = srd;
    v.e_mack  = mack;
    v.e_sreq  = sreq;
    v.e_srw   = cur_rw;
    v.e_saddr = cur_addr;
    v.e_swd   = cur_wd;
    v.e_busy  = bsy;
    v.e_rdata = rdata;
    v.e_tcnt  = tcnt;
    vecs[n_rows] = v;
    n_rows++;
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic check_all(input string tag, input int idx, input logic [3:0] e_mack,
                           input logic e_sreq, input logic e_srw, input logic [15:0] e_saddr,
                           input logic [31:0] e_swd, input logic e_busy,
                           input logic [31:0] e_rdata, input logic [15:0] e_tcnt);
    n_vec++;
    if (m_ack !== e_mack || slv_req !== e_sreq || slv_rd_wr_L !== e_srw ||
        slv_addr !== e_saddr || slv_wr_data !== e_swd || busy !== e_busy ||
        m_rd_data !== e_rdata || timeout_count !== e_tcnt) begin
      n_miss++;
      $display("FAIL %s[%0d]: got mack=%b sreq=%b rw=%b addr=%h wd=%h busy=%b rd=%h tc=%0d, want mack=%b sreq=%b rw=%b addr=%h wd=%h busy=%b rd=%h tc=%0d",
               tag, idx, m_ack, slv_req, slv_rd_wr_L, slv_addr, slv_wr_data, busy, m_rd_data,
               timeout_count, e_mack, e_sreq, e_srw, e_saddr, e_swd, e_busy, e_rdata, e_tcnt);
    end
  endtask

  // ---------------- table contents ----------------
  task automatic fill_table();
    n_rows = 0;
    // Round robin from reset: all four held, slave acks immediately.
    slv(A0, D0, 1'b1);
    add(4'b1111, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h0,  16'd0);
    add(4'b1111, 4'b1111, 1'b1, 32'h11, 4'b0001, 1'b0, 1'b1, 32'h11, 16'd0);
    add(4'b1110, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h11, 16'd0);
    slv(A1, D1, 1'b1);
    add(4'b1111, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h11, 16'd0);
    add(4'b1111, 4'b1111, 1'b1, 32'h22, 4'b0010, 1'b0, 1'b1, 32'h22, 16'd0);
    add(4'b1101, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h22, 16'd0);
    slv(A2, D2, 1'b1);
    add(4'b1111, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h22, 16'd0);
    add(4'b1111, 4'b1111, 1'b1, 32'h33, 4'b0100, 1'b0, 1'b1, 32'h33, 16'd0);
    add(4'b1011, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h33, 16'd0);
    slv(A3, D3, 1'b1);
    add(4'b1111, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h33, 16'd0);
    add(4'b1111, 4'b1111, 1'b1, 32'h44, 4'b1000, 1'b0, 1'b1, 32'h44, 16'd0);
    add(4'b0111, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h44, 16'd0);
    slv(A0, D0, 1'b1);
    add(4'b1111, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h44, 16'd0);
    add(4'b1111, 4'b1111, 1'b1, 32'h55, 4'b0001, 1'b0, 1'b1, 32'h55, 16'd0);
    add(4'b0000, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h55, 16'd0);
    // Single read by master 2, slave acks one cycle after slv_req.
    slv(A2, D2, 1'b1);
    add(4'b0100, 4'b1111, 1'b0, 32'h0,          4'b0000, 1'b1, 1'b1, 32'h55,         16'd0);
    add(4'b0100, 4'b1111, 1'b0, 32'h0,          4'b0000, 1'b1, 1'b1, 32'h55,         16'd0);
    add(4'b0100, 4'b1111, 1'b1, 32'h1234_5678,  4'b0100, 1'b0, 1'b1, 32'h1234_5678,  16'd0);
    add(4'b0000, 4'b1111, 1'b0, 32'h0,          4'b0000, 1'b0, 1'b0, 32'h1234_5678,  16'd0);
    // Write by master 1 also returns slave read data.
    slv(A1, D1, 1'b0);
    add(4'b0010, 4'b1101, 1'b0, 32'h0,          4'b0000, 1'b1, 1'b1, 32'h1234_5678,  16'd0);
    add(4'b0010, 4'b1101, 1'b1, 32'h0BAD_F00D,  4'b0010, 1'b0, 1'b1, 32'h0BAD_F00D,  16'd0);
    add(4'b0000, 4'b1101, 1'b0, 32'h0,          4'b0000, 1'b0, 1'b0, 32'h0BAD_F00D,  16'd0);
    // Timeout on master 3: slv_req high TIMEOUT+1 cycles, then dead_beef.
    slv(A3, D3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      add(4'b1000, 4'b1111, 1'b0, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0BAD_F00D, 16'd0);
    end
    add(4'b1000, 4'b1111, 1'b0, 32'h0,          4'b1000, 1'b0, 1'b1, 32'hDEAD_BEEF,  16'd1);
    // Late slave acks are ignored in WAIT_DROP and in IDLE.
    add(4'b0000, 4'b1111, 1'b1, 32'h5555_5555,  4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF,  16'd1);
    add(4'b0000, 4'b1111, 1'b1, 32'h5555_5555,  4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF,  16'd1);
    // Ack on the expiry cycle wins: data returned, count unchanged.
    slv(A0, D0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      add(4'b0001, 4'b1111, 1'b0, 32'h0, 4'b0000, 1'b1, 1'b1, 32'hDEAD_BEEF, 16'd1);
    end
    add(4'b0001, 4'b1111, 1'b1, 32'h77, 4'b0001, 1'b0, 1'b1, 32'h77, 16'd1);
    add(4'b0000, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h77, 16'd1);
    // Master 1 holds its request 10 cycles after ack; master 2 must wait.
    slv(A1, D1, 1'b1);
    add(4'b0110, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h77, 16'd1);
    add(4'b0110, 4'b1111, 1'b1, 32'h88, 4'b0010, 1'b0, 1'b1, 32'h88, 16'd1);
    for (int i = 0; i < 10; i++) begin
      add(4'b0110, 4'b1111, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h88, 16'd1);
    end
    add(4'b0100, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h88, 16'd1);
    slv(A2, D2, 1'b1);
    add(4'b0100, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h88, 16'd1);
    add(4'b0100, 4'b1111, 1'b1, 32'h99, 4'b0100, 1'b0, 1'b1, 32'h99, 16'd1);
    add(4'b0000, 4'b1111, 1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h99, 16'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    n_vec     = 0;
    n_miss    = 0;
    reset_n   = 1'b0;
    m_req     = '0;
    m_rd_wr_L = '1;
    m_addr    = {A3, A2, A1, A0};
    m_wr_data = {D3, D2, D1, D0};
    slv_ack   = 1'b0;
    slv_rd_data = '0;
    fill_table();

    repeat (2) @(negedge clk);
    check_all("reset", 0, 4'b0000, 1'b0, 1'b1, 16'h0, 32'h0, 1'b0, 32'h0, 16'd0);
    n_vec++;
    if (state_dbg !== 2'd0) begin
      n_miss++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    reset_n = 1'b1;

    for (int i = 0; i < n_rows; i++) begin
      m_req       = vecs[i].req;
      m_rd_wr_L   = vecs[i].rdwr;
      slv_ack     = vecs[i].ack;
      slv_rd_data = vecs[i].srd;
      @(negedge clk);
      check_all("vec", i, vecs[i].e_mack, vecs[i].e_sreq, vecs[i].e_srw, vecs[i].e_saddr,
                vecs[i].e_swd, vecs[i].e_busy, vecs[i].e_rdata, vecs[i].e_tcnt);
    end

    // Reset in the middle of an access: master 0 granted, slave silent.
    m_req       = 4'b0001;
    m_rd_wr_L   = 4'b1111;
    slv_ack     = 1'b0;
    slv_rd_data = '0;
    @(negedge clk);
    check_all("rst_pre", 0, 4'b0000, 1'b1, 1'b1, A0, D0, 1'b1, 32'h99, 16'd1);
    #2 reset_n = 1'b0;
    #1 check_all("rst_async", 0, 4'b0000, 1'b0, 1'b1, 16'h0, 32'h0, 1'b0, 32'h0, 16'd0);
    @(negedge clk);
    check_all("rst_hold", 0, 4'b0000, 1'b0, 1'b1, 16'h0, 32'h0, 1'b0, 32'h0, 16'd0);
    // Full contention after release: master 0 must win again.
    m_req   = 4'b1111;
    reset_n = 1'b1;
    @(negedge clk);
    check_all("rst_rr", 0, 4'b0000, 1'b1, 1'b1, A0, D0, 1'b1, 32'h0, 16'd0);
    slv_ack     = 1'b1;
    slv_rd_data = 32'h0000_0F00;
    @(negedge clk);
    check_all("rst_ack", 0, 4'b0001, 1'b0, 1'b1, A0, D0, 1'b1, 32'h0000_0F00, 16'd0);
    m_req   = 4'b0000;
    slv_ack = 1'b0;
    @(negedge clk);
    check_all("rst_idle", 0, 4'b0000, 1'b0, 1'b1, A0, D0, 1'b0, 32'h0000_0F00, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
